// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between the core load/store path and the loader.
// One access is in flight at a time, and read data returns after MEM_LAT cycles.
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_LAT   = 1,
   parameter int CORE_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              owner_q, owner_d, last_q, last_d, we_q, we_d, sel_ldr;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   // owner/last encoding: 0 = core, 1 = loader
   assign sel_ldr = ldr_req & (~core_req | (CORE_PRIO == 0 && !last_q));
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: if (core_req | ldr_req) begin
            state_d = ACCESS;
            owner_d = sel_ldr;
            last_d  = sel_ldr;
            we_d    = sel_ldr ? ldr_we : core_we;
            addr_d  = sel_ldr ? ldr_addr : core_addr;
            wdata_d = sel_ldr ? ldr_wdata : core_wdata;
         end
         ACCESS: begin
            state_d = we_q ? IDLE : (MEM_LAT == 1 ? RESP : WAIT);
            cnt_d   = CW'(MEM_LAT - 1);
         end
         // leave WAIT on the edge where the count would reach zero
         WAIT: begin
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q <= CW'(1) ? RESP : WAIT;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      mem_read    = state_q == ACCESS && !we_q;
      mem_write   = state_q == ACCESS && we_q;
      mem_addr    = addr_q;
      mem_wdata   = wdata_q;
      core_gnt    = state_q == ACCESS && !owner_q;
      ldr_gnt     = state_q == ACCESS && owner_q;
      core_rvalid = state_q == RESP && !owner_q;
      ldr_rvalid  = state_q == RESP && owner_q;
      core_rdata  = core_rvalid ? mem_rdata : '0;
      ldr_rdata   = ldr_rvalid ? mem_rdata : '0;
      core_stall  = core_req & ~(core_we ? core_gnt : core_rvalid);
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of a round-robin and a core-priority arbiter (MEM_LAT=3)
// driven by the same stimulus.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst, core_req, core_we, ldr_req, ldr_we;
   logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata, mem_rdata;
   logic        a_core_gnt, a_core_rvalid, a_core_stall, a_ldr_gnt, a_ldr_rvalid, a_mem_read, a_mem_write;
   logic [31:0] a_core_rdata, a_ldr_rdata, a_mem_addr, a_mem_wdata;
   logic        b_core_gnt, b_core_rvalid, b_core_stall, b_ldr_gnt, b_ldr_rvalid, b_mem_read, b_mem_write;
   logic [31:0] b_core_rdata, b_ldr_rdata, b_mem_addr, b_mem_wdata;
   int          checks = 0, errors = 0;
   logic        own;
   always #5 clk = ~clk;
   dmem_arbiter #(.MEM_LAT(3), .CORE_PRIO(0)) u_rr (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(a_core_gnt), .core_rvalid(a_core_rvalid), .core_rdata(a_core_rdata), .core_stall(a_core_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(a_ldr_gnt), .ldr_rvalid(a_ldr_rvalid), .ldr_rdata(a_ldr_rdata),
      .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(mem_rdata)
   );
   dmem_arbiter #(.MEM_LAT(3), .CORE_PRIO(1)) u_prio (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(b_core_gnt), .core_rvalid(b_core_rvalid), .core_rdata(b_core_rdata), .core_stall(b_core_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(b_ldr_gnt), .ldr_rvalid(b_ldr_rvalid), .ldr_rdata(b_ldr_rdata),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(mem_rdata)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1; core_req = 1'b1; ldr_req = 1'b1; core_we = 1'b0; ldr_we = 1'b0;
      core_addr = 32'h100; ldr_addr = 32'h200; core_wdata = '0; ldr_wdata = '0; mem_rdata = '0;
      step; step;
      chk("rst_core_gnt", {31'b0, a_core_gnt}, 0);
      chk("rst_ldr_gnt", {31'b0, a_ldr_gnt}, 0);
      chk("rst_rvalid", {30'b0, a_core_rvalid, a_ldr_rvalid}, 0);
      chk("rst_strobes", {30'b0, a_mem_read, a_mem_write}, 0);
      chk("rst_mem_addr", a_mem_addr, 0);
      chk("rst_mem_wdata", a_mem_wdata, 0);
      chk("rst_rdata", a_core_rdata | a_ldr_rdata, 0);
      rst = 1'b0;
      // continuous conflicting reads: rr alternates core/loader, prio always core
      step;
      for (int k = 0; k < 4; k++) begin
         own = k[0];
         mem_rdata = 32'hA000_0000 + k;
         chk("rr_core_gnt", {31'b0, a_core_gnt}, {31'b0, ~own});
         chk("rr_ldr_gnt", {31'b0, a_ldr_gnt}, {31'b0, own});
         chk("rr_mem_addr", a_mem_addr, own ? 32'h200 : 32'h100);
         chk("rr_mem_read", {31'b0, a_mem_read}, 1);
         chk("prio_core_gnt", {31'b0, b_core_gnt}, 1);
         chk("prio_ldr_gnt", {31'b0, b_ldr_gnt}, 0);
         step;
         chk("rr_wait_read", {31'b0, a_mem_read}, 0);
         step;
         chk("rr_early_rvalid", {30'b0, a_core_rvalid, a_ldr_rvalid}, 0);
         step;
         chk("rr_core_rvalid", {31'b0, a_core_rvalid}, {31'b0, ~own});
         chk("rr_ldr_rvalid", {31'b0, a_ldr_rvalid}, {31'b0, own});
         chk("rr_core_rdata", a_core_rdata, own ? 32'h0 : mem_rdata);
         chk("rr_ldr_rdata", a_ldr_rdata, own ? mem_rdata : 32'h0);
         chk("prio_core_rvalid", {31'b0, b_core_rvalid}, 1);
         step;
         chk("rr_idle_gnt", {30'b0, a_core_gnt, a_ldr_gnt}, 0);
         step;
      end
      // fifth grant is a core read in both; reset it during WAIT
      chk("rw_core_gnt", {31'b0, a_core_gnt}, 1);
      ldr_req = 1'b0;
      step;
      rst = 1'b1;
      step;
      rst = 1'b0; core_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rw_core_rvalid", {30'b0, a_core_rvalid, b_core_rvalid}, 0);
         step;
      end
      // single core store
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
      #1;
      chk("st_stall_before", {31'b0, a_core_stall}, 1);
      step;
      chk("st_core_gnt", {31'b0, a_core_gnt}, 1);
      chk("st_mem_write", {31'b0, a_mem_write}, 1);
      chk("st_mem_read", {31'b0, a_mem_read}, 0);
      chk("st_mem_addr", a_mem_addr, 32'h10);
      chk("st_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
      chk("st_stall_gnt", {31'b0, a_core_stall}, 0);
      step;
      chk("st_gnt_pulse", {31'b0, a_core_gnt}, 0);
      chk("st_write_pulse", {31'b0, a_mem_write}, 0);
      // back-to-back stores, one grant every 2 cycles
      for (int i = 0; i < 3; i++) begin
         core_addr = 32'(4 * i); core_wdata = 32'(i + 1);
         step;
         chk("b2b_gnt", {31'b0, a_core_gnt}, 1);
         chk("b2b_addr", a_mem_addr, 32'(4 * i));
         chk("b2b_wdata", a_mem_wdata, 32'(i + 1));
         step;
         chk("b2b_gap", {31'b0, a_core_gnt}, 0);
      end
      core_req = 1'b0; core_we = 1'b0;
      step;
      chk("b2b_no_repeat", {30'b0, a_core_gnt, a_mem_write}, 0);
      // loader read with 3-cycle latency
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h20; mem_rdata = 32'h12345678;
      step;
      chk("ld_gnt", {31'b0, a_ldr_gnt}, 1);
      chk("ld_mem_read", {31'b0, a_mem_read}, 1);
      chk("ld_mem_addr", a_mem_addr, 32'h20);
      chk("ld_core_gnt", {31'b0, a_core_gnt}, 0);
      step; step;
      chk("ld_early_rvalid", {31'b0, a_ldr_rvalid}, 0);
      step;
      chk("ld_rvalid", {31'b0, a_ldr_rvalid}, 1);
      chk("ld_rdata", a_ldr_rdata, 32'h12345678);
      chk("ld_core_rvalid", {31'b0, a_core_rvalid}, 0);
      chk("ld_core_rdata", a_core_rdata, 0);
      chk("ld_core_stall", {31'b0, a_core_stall}, 0);
      ldr_req = 1'b0;
      step;
      chk("ld_rvalid_pulse", {31'b0, a_ldr_rvalid}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
